// File: rtl/timer_pkg.sv
// Package for the memory-mapped countdown timer.
// Holds the FSM state encoding, register offsets inside the 16-byte window,
// CTRL bit positions, MODE codes and the byte-lane merge helper.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_PRESET = 4'h4;
  localparam logic [3:0] OFF_COUNT  = 4'h8;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Only the exact 01 code reloads; 00, 10 and 11 all behave as one-shot.
  function automatic logic is_reload(input logic [1:0] mode);
    return (mode == MODE_RELOAD);
  endfunction

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                              input logic [31:0] wr_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? wr_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_if.sv
// CPU data-port bus as seen by the timer.
//   addr   : byte address from the CPU
//   byteen : byte write enables, any bit set marks a store
//   wdata  : store data
//   rdata  : load data returned by the responder (combinational)
// master modport is the CPU side, slave modport is the timer side.
interface timer_if;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output byteen, output wdata, input rdata);
  modport slave  (input addr, input byteen, input wdata, output rdata);
endinterface

// File: rtl/timer_prescaler.sv
// Tick generator for the countdown timer.
// While i_run is high, o_tick pulses once every PRESCALE cycles; the counter
// restarts from zero whenever i_run is low, so every count phase begins with
// a full prescale period.
// Ports:
//   clk    : clock
//   reset  : asynchronous active-low reset
//   i_run  : timer is in a counting state
//   o_tick : decrement permitted this cycle
module timer_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  output logic o_tick
);

  localparam int W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

  logic [W-1:0] r_cnt;

  assign o_tick = i_run && (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!i_run || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with interrupt output.
// Registers in a 16-byte window at BASE_ADDR:
//   +0 CTRL   [0]=EN [2:1]=MODE [3]=IM, upper bits read 0
//   +4 PRESET 32-bit R/W, byte-lane merged
//   +8 COUNT  read-only
//   +C and any address outside the window read 0 and drop writes.
// Ports:
//   clk   : clock, all state changes on posedge
//   reset : asynchronous active-low reset
//   bus   : timer_if.slave (addr, byteen, wdata in; rdata out)
//   irq   : registered interrupt request, IM & pending
// Optional feature: define TIMER_PRESCALE_EN to decrement COUNT only on
// every PRESCALE-th cycle of counting (uses timer_prescaler).
module timer_dev
  import timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int unsigned PRESCALE  = 4
) (
  input  logic    clk,
  input  logic    reset,
  timer_if.slave  bus,
  output logic    irq
);

  state_t      r_state;
  logic        r_en;
  logic [1:0]  r_mode;
  logic        r_im;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_pending;
  logic        r_irq;

  logic        w_hit;
  logic [3:0]  w_off;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_tick;

  state_t      w_state_nxt;
  logic        w_en_nxt;
  logic [1:0]  w_mode_nxt;
  logic        w_im_nxt;
  logic [31:0] w_count_nxt;
  logic        w_pend_nxt;

  // Address decode: byte offset bits [1:0] are ignored.
  assign w_hit       = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign w_off       = {bus.addr[3:2], 2'b00};
  assign w_wr        = w_hit && (bus.byteen != 4'b0000);
  assign w_wr_ctrl   = w_wr && (w_off == OFF_CTRL);
  assign w_wr_preset = w_wr && (w_off == OFF_PRESET);

`ifdef TIMER_PRESCALE_EN
  logic w_run;
  assign w_run = (r_state == ST_LOAD) || (r_state == ST_CNT);

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .i_run  (w_run),
    .o_tick (w_tick)
  );
`else
  // Every counting cycle is a decrement; PRESCALE has no effect here.
  assign w_tick = 1'b1 | (PRESCALE == 0);
`endif

  always_comb begin
    bus.rdata = 32'h0;
    if (w_hit) begin
      case (w_off)
        OFF_CTRL:   bus.rdata = {28'h0, r_im, r_mode, r_en};
        OFF_PRESET: bus.rdata = r_preset;
        OFF_COUNT:  bus.rdata = r_count;
        default:    bus.rdata = 32'h0;
      endcase
    end
  end

  // Next-state logic. The FSM acts on the registered CTRL bits; a CPU store
  // to CTRL is applied afterwards so it overrides any FSM change to CTRL.
  always_comb begin
    w_state_nxt = r_state;
    w_en_nxt    = r_en;
    w_mode_nxt  = r_mode;
    w_im_nxt    = r_im;
    w_count_nxt = r_count;
    // Any store hitting CTRL acknowledges the interrupt; an expiry on the
    // same edge sets it again below so the event is not lost.
    w_pend_nxt  = r_pending && !w_wr_ctrl;

    case (r_state)
      ST_IDLE: begin
        // COUNT is loaded on the edge that enters LOAD, so LOAD is already
        // the first counting cycle.
        if (r_en) begin
          w_count_nxt = r_preset;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD, ST_CNT: begin
        if (!r_en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count <= 32'd1) begin
          w_count_nxt = 32'd0;
          w_pend_nxt  = 1'b1;
          w_state_nxt = ST_INT;
        end else begin
          w_state_nxt = ST_CNT;
          if (w_tick) begin
            w_count_nxt = r_count - 32'd1;
          end
        end
      end
      ST_INT: begin
        w_state_nxt = ST_IDLE;
        if (is_reload(r_mode)) begin
          w_pend_nxt = 1'b0;
        end else begin
          w_en_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_wr_ctrl && bus.byteen[0]) begin
      w_en_nxt   = bus.wdata[CTRL_EN];
      w_mode_nxt = bus.wdata[CTRL_MODE_HI:CTRL_MODE_LO];
      w_im_nxt   = bus.wdata[CTRL_IM];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_en      <= 1'b0;
      r_mode    <= MODE_ONESHOT;
      r_im      <= 1'b0;
      r_preset  <= 32'h0;
      r_count   <= 32'h0;
      r_pending <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_en      <= w_en_nxt;
      r_mode    <= w_mode_nxt;
      r_im      <= w_im_nxt;
      r_count   <= w_count_nxt;
      r_pending <= w_pend_nxt;
      // Built from next-state values so irq rises on the same edge as pending.
      r_irq     <= w_im_nxt && w_pend_nxt;
      if (w_wr_preset) begin
        r_preset <= merge_lanes(r_preset, bus.wdata, bus.byteen);
      end
    end
  end

  assign irq = r_irq;

endmodule
